legv8_control_pipe: RTL
=======================

# legv8_control_pipe

Pipelined LEGv8 control unit. Decodes the 11-bit ID-stage opcode into an extended control word and registers it into the ID/EX boundary. Detects load-use hazards and inserts one-cycle bubbles. Applies a parametrised multi-cycle IF/ID flush after a taken branch. It sits between the IF/ID register and the ID/EX register of the 5-stage datapath.

## Interface
- `REG_W`, 5: register index width; the zero register is index all-ones (XZR = 31).
- `FLUSH_DEPTH`, 1: number of cycles `if_flush` stays high per taken branch. Legal range 1..7.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: the IF/ID slot holds a real instruction.
- `opcode` in 11: instr[31:21].
- `id_rn` in REG_W: instr[9:5].
- `id_rm` in REG_W: instr[20:16].
- `id_rd` in REG_W: instr[4:0] (Rd/Rt).
- `branch_taken` in 1: branch resolved taken, from the EX/MEM stage.
- `ex_ctrl` out 11: registered control word {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBr, BranchNZ, ALUOp[1:0]}.
- `ex_valid` out 1: registered; `ex_ctrl` holds a real instruction.
- `ex_rd` out REG_W: registered destination index.
- `stall` out 1: combinational; holds PC and IF/ID.
- `if_flush` out 1: combinational; zeroes IF/ID.
- `illegal` out 1: registered one-cycle pulse.
- `illegal_seen` out 1: sticky flag.

## Operation
Decode table (x = don't care). ALUOp encoding: 00 add, 01 pass-B, 10 funct (R-type), 11 subtract.
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
  - RegWrite=1, ALUOp=10.
  - Sources: Rn, Rm.
- ADDI 1001000100x: ALUSrc=1, RegWrite=1, ALUOp=00. Source: Rn.
- SUBI 1101000100x: ALUSrc=1, RegWrite=1, ALUOp=11. Source: Rn.
- LDUR 11111000010: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00. Source: Rn.
- STUR 11111000000: Reg2Loc=1, ALUSrc=1, MemWrite=1, ALUOp=00. Sources: Rn, Rt.
- CBZ 10110100xxx: Reg2Loc=1, Branch=1, ALUOp=01. Source: Rt.
- CBNZ 10110101xxx: Reg2Loc=1, Branch=1, BranchNZ=1, ALUOp=01. Source: Rt.
- B 000101xxxxx: UncondBr=1, all other bits 0. No sources.
- 00000000000 = NOP: all bits 0, not illegal.

Bubble: `ex_ctrl`=0, `ex_valid`=0, `ex_rd`=0.

Load-use hazard: `hz` = `id_valid` & `ex_valid` & `ex_ctrl`.MemRead & (`ex_rd` != XZR) & (`ex_rd` matches a source the ID instruction uses).
- The second source is `id_rd` when Reg2Loc=1, otherwise `id_rm`.
- Only sources listed in the decode table are compared.
- When `hz`=1: `stall`=1 and a bubble is clocked into ID/EX. Because the bubble clears MemRead, the stall self-clears after exactly one cycle.

Flush:
- `if_flush` = `branch_taken` | (`cnt` != 0).
- When `branch_taken`=1, `cnt` loads FLUSH_DEPTH-1. Otherwise `cnt` decrements while non-zero.
- A `branch_taken` arriving while `cnt` != 0 reloads the counter; the flush window restarts.
- Whenever `if_flush`=1, a bubble is clocked into ID/EX, `stall` is forced to 0, and `illegal` is suppressed.

Priority, highest first: `reset` > flush > hazard > normal decode.

`id_valid`=0: bubble, no hazard, no illegal.

## Timing
- Decode latency is one cycle: the opcode present at edge N appears on `ex_ctrl` after edge N.
- `stall` and `if_flush` are combinational in the same cycle as their inputs. There is no path from `ex_*` back to `opcode`, so no combinational loop.
- Reset values: `ex_ctrl`=0, `ex_valid`=0, `ex_rd`=0, `cnt`=0, `illegal`=0, `illegal_seen`=0. `stall`=0 and `if_flush`=`branch_taken` during reset.
- Reset asserted mid-flush or mid-stall clears all state on that edge. The first post-reset cycle decodes normally.
- Load-use with `ex_rd`=31 does not stall.
- A back-to-back LDUR followed by a dependent LDUR stalls once, not twice.

## Configuration
- `LEGV8_ILLEGAL_TRAP_EN` defined:
  - An unlisted opcode with `id_valid`=1 and no flush produces a bubble.
  - `illegal` pulses high for one cycle, aligned with the `ex_ctrl` update.
  - `illegal_seen` sets and holds until `reset`.
- Not defined:
  - Unlisted opcodes produce a bubble.
  - `illegal` and `illegal_seen` are tied to 0.

## Test plan
- Reset, then opcode ADD 10001011000, `id_rd`=3 -> next cycle `ex_ctrl`=11'b00010000010, `ex_valid`=1, `ex_rd`=3.
- LDUR with `id_rd`=5, then ADD with `id_rn`=5 -> one cycle of `stall`=1 and a bubble in ID/EX; ADD decodes on the following edge. Repeat with `id_rd`=31 -> no stall.
- STUR with Rt (`id_rd`)=7 following LDUR to X7 -> stall via the Reg2Loc path. ADD with `id_rm`=7 but Reg2Loc=0 and `id_rn`≠7 -> stalls via the Rm path.
- FLUSH_DEPTH=3: `branch_taken` pulse at cycle 10 -> `if_flush` high cycles 10–12 and 3 bubbles. A second pulse at cycle 11 -> `if_flush` high through cycle 13.
- `branch_taken` in the same cycle as a load-use hazard -> `stall`=0, `if_flush`=1, bubble.
- Opcode 11111111111 with the macro defined -> `illegal`=1 for one cycle, `illegal_seen`=1 until `reset`. Without the macro, both stay 0 and a bubble is produced.

Source files
------------

// File: rtl/legv8_control_pipe.sv
// LEGv8 ID-stage control: opcode decode into the ID/EX register, load-use stall, multi-cycle flush.
// Optional illegal-opcode trap enabled by defining LEGV8_ILLEGAL_TRAP_EN.
module legv8_control_pipe #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic [10:0]      opcode_i,
    input  logic [REG_W-1:0] id_rn_i,
    input  logic [REG_W-1:0] id_rm_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             branch_taken_i,
    output logic [10:0]      ex_ctrl_o,
    output logic             ex_valid_o,
    output logic [REG_W-1:0] ex_rd_o,
    output logic             stall_o,
    output logic             if_flush_o,
    output logic             illegal_o,
    output logic             illegal_seen_o
);

    localparam logic [REG_W-1:0] Xzr = '1;

    logic [10:0]      ex_ctrl_q, ex_ctrl_d;
    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic [2:0]       cnt_q, cnt_d;

    logic [10:0]      ctrl;
    logic             legal, use_rn, use_r2, hz, issue;
    logic [REG_W-1:0] src2;

    // Control word: {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
    //                Branch, UncondBr, BranchNZ, ALUOp[1:0]}
    always_comb begin
        ctrl   = '0;
        legal  = 1'b0;
        use_rn = 1'b0;
        use_r2 = 1'b0;
        casez (opcode_i)
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
                ctrl = 11'b00010000010; legal = 1'b1; use_rn = 1'b1; use_r2 = 1'b1;
            end
            11'b1001000100?: begin ctrl = 11'b01010000000; legal = 1'b1; use_rn = 1'b1; end
            11'b1101000100?: begin ctrl = 11'b01010000011; legal = 1'b1; use_rn = 1'b1; end
            11'b11111000010: begin ctrl = 11'b01111000000; legal = 1'b1; use_rn = 1'b1; end
            11'b11111000000: begin
                ctrl = 11'b11000100000; legal = 1'b1; use_rn = 1'b1; use_r2 = 1'b1;
            end
            11'b10110100???: begin ctrl = 11'b10000010001; legal = 1'b1; use_r2 = 1'b1; end
            11'b10110101???: begin ctrl = 11'b10000010101; legal = 1'b1; use_r2 = 1'b1; end
            11'b000101?????: begin ctrl = 11'b00000001000; legal = 1'b1; end
            11'b00000000000: legal = 1'b1;
            default: ;
        endcase
    end

    // Reg2Loc selects Rt as the second read port.
    assign src2 = ctrl[10] ? id_rd_i : id_rm_i;

    assign hz = id_valid_i & ex_valid_q & ex_ctrl_q[6] & (ex_rd_q != Xzr) &
                ((use_rn & (ex_rd_q == id_rn_i)) | (use_r2 & (ex_rd_q == src2)));

    assign if_flush_o = branch_taken_i | (~reset_i & (cnt_q != 3'd0));
    assign stall_o    = hz & ~if_flush_o & ~reset_i;
    assign issue      = id_valid_i & legal & ~if_flush_o & ~hz;

    always_comb begin
        ex_ctrl_d  = issue ? ctrl : 11'd0;
        ex_valid_d = issue;
        ex_rd_d    = issue ? id_rd_i : '0;
        cnt_d      = cnt_q;
        if (branch_taken_i) begin
            cnt_d = 3'(FLUSH_DEPTH - 1);
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_ctrl_q  <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            cnt_q      <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_ctrl_o  = ex_ctrl_q;
    assign ex_valid_o = ex_valid_q;
    assign ex_rd_o    = ex_rd_q;

`ifdef LEGV8_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d, illegal_seen_q;

    assign illegal_d = id_valid_i & ~legal & ~if_flush_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            illegal_q      <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_q      <= illegal_d;
            illegal_seen_q <= illegal_seen_q | illegal_d;
        end
    end

    assign illegal_o      = illegal_q;
    assign illegal_seen_o = illegal_seen_q;
`else
    assign illegal_o      = 1'b0;
    assign illegal_seen_o = 1'b0;
`endif

endmodule
